// File: rtl/sdp_ram_arbiter_if.sv
// Client-side bundle for sdp_ram_arbiter: two write requesters and one read port.
// The master modport is the client logic; the slave modport is the arbiter.
interface sdp_ram_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) ();
    logic                     a_req;
    logic [ADDRESS_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0]    a_data;
    logic                     a_gnt;
    logic                     b_req;
    logic [ADDRESS_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0]    b_data;
    logic                     b_gnt;
    logic                     rd_req;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rd_data;

    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data, rd_req, rd_addr,
        input  a_gnt, b_gnt, rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data, rd_req, rd_addr,
        output a_gnt, b_gnt, rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sdp_ram_arbiter.sv
// Round-robin two-writer / one-reader controller for a simple-dual-port RAM with
// write-to-read forwarding. SDP_RAM_ARBITER_INIT_CLEAR_EN adds a post-reset zero sweep.
module sdp_ram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sdp_ram_arbiter_if.slave         client,
    output logic                     busy,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic [ADDRESS_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);
    logic                  run;
    logic                  a_gnt;
    logic                  b_gnt;
    logic                  last_b;
    logic                  rd_accept;
    logic                  byp;
    logic [DATA_WIDTH-1:0] byp_data;

`ifdef SDP_RAM_ARBITER_INIT_CLEAR_EN
    typedef enum logic {INIT, RUN} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] clr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state <= state_next;
            busy  <= (state_next == INIT);
            if (state == INIT)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clr_addr == '1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run = (state == RUN);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // last_b set means B won most recently, so A takes the next tie.
    assign a_gnt = run & client.a_req & (~client.b_req | last_b);
    assign b_gnt = run & client.b_req & (~client.a_req | ~last_b);

    always_comb begin
        ram_we    = a_gnt | b_gnt;
        ram_waddr = client.a_addr;
        ram_wdata = client.a_data;
`ifdef SDP_RAM_ARBITER_INIT_CLEAR_EN
        if (state == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else
`endif
        if (b_gnt) begin
            ram_waddr = client.b_addr;
            ram_wdata = client.b_data;
        end
    end

    assign rd_accept = client.rd_req & run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b          <= 1'b1;
            client.rd_valid <= 1'b0;
            byp             <= 1'b0;
            byp_data        <= '0;
        end else begin
            if (a_gnt)
                last_b <= 1'b0;
            else if (b_gnt)
                last_b <= 1'b1;
            client.rd_valid <= rd_accept;
            byp             <= rd_accept & ram_we & (ram_waddr == client.rd_addr);
            byp_data        <= ram_wdata;
        end
    end

    assign client.a_gnt    = a_gnt;
    assign client.b_gnt    = b_gnt;
    assign client.rd_ready = run;
    assign client.rd_data  = byp ? byp_data : ram_rdata;
    assign ram_raddr       = client.rd_addr;
endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed table-driven bench for sdp_ram_arbiter with a read-first registered RAM model.
module tb_sdp_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] mem [2**AW];

    int pass_cnt = 0;
    int total_cnt = 0;

    sdp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sdp_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .client    (bus.slave),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    typedef struct {
        logic          a_req;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        logic          b_req;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          a_gnt;
        logic          b_gnt;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          rd_valid;
        logic          chk_data;
        logic [DW-1:0] rd_data;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic idle_inputs();
        bus.a_req  = 1'b0; bus.a_addr  = '0; bus.a_data = '0;
        bus.b_req  = 1'b0; bus.b_addr  = '0; bus.b_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
    endtask

    // Called at a negedge right after reset release; b_req is held high throughout.
    task automatic sweep_check(input string tag);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_we"}, 32'(ram_we), 32'd1);
            chk({tag, "_waddr"}, 32'(ram_waddr), 32'(k));
            chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
            chk({tag, "_gnt"}, 32'({bus.a_gnt, bus.b_gnt, bus.rd_ready}), 32'd0);
            chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_first_run_gnt"}, 32'(bus.b_gnt), 32'd1);
        chk({tag, "_first_run_waddr"}, 32'(ram_waddr), 32'hf);
    endtask

    initial begin
        //          a_req a_addr a_data b_req b_addr b_data rd rd_a  agnt bgnt we waddr wdata  rv cd rd_data
        vecs[0]  = '{1'b1, 4'd1, 8'h10, 1'b1, 4'd2, 8'h20, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h10, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h21, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 8'h21, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 4'd1, 8'h12, 1'b1, 4'd2, 8'h22, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h12, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 4'd1, 8'h13, 1'b1, 4'd2, 8'h23, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 8'h23, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'h44, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h45, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h45, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h46, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6, 8'h46, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 4'd3, 8'h5a, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h5a, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h5a};
        vecs[11] = '{1'b1, 4'd7, 8'hc3, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 4'd7, 8'hc3, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hc3};
        vecs[13] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hc3};
        vecs[15] = '{1'b1, 4'd8, 8'h18, 1'b1, 4'd9, 8'h29, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 8'h29, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        ram_rdata = '0;
        idle_inputs();
        rst_n = 1'b0;
        bus.b_req  = 1'b1;
        bus.b_addr = 4'hf;
        bus.b_data = 8'h11;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
`ifdef SDP_RAM_ARBITER_INIT_CLEAR_EN
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_gnt", 32'({bus.a_gnt, bus.b_gnt, bus.rd_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("sweep1");
`else
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_ready", 32'(bus.rd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        @(negedge clk);
        idle_inputs();

        for (int i = 0; i < 16; i++) begin
            bus.a_req  = vecs[i].a_req;  bus.a_addr  = vecs[i].a_addr; bus.a_data = vecs[i].a_data;
            bus.b_req  = vecs[i].b_req;  bus.b_addr  = vecs[i].b_addr; bus.b_data = vecs[i].b_data;
            bus.rd_req = vecs[i].rd_req; bus.rd_addr = vecs[i].rd_addr;
            #1;
            chk($sformatf("v%0d_a_gnt", i), 32'(bus.a_gnt), 32'(vecs[i].a_gnt));
            chk($sformatf("v%0d_b_gnt", i), 32'(bus.b_gnt), 32'(vecs[i].b_gnt));
            chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].waddr));
                chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdata));
            end
            chk($sformatf("v%0d_rd_ready", i), 32'(bus.rd_ready), 32'd1);
            chk($sformatf("v%0d_raddr", i), 32'(ram_raddr), 32'(vecs[i].rd_addr));
            chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].rd_valid));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(vecs[i].rd_data));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Reset while a read is in flight: rd_valid must drop at once.
        idle_inputs();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd3;
        @(posedge clk);
        #2;
        chk("inflight_rd_valid", 32'(bus.rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
`ifdef SDP_RAM_ARBITER_INIT_CLEAR_EN
        rst_n = 1'b1;
        bus.rd_req = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("midsweep_waddr", 32'(ram_waddr), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("midsweep_rst_waddr", 32'(ram_waddr), 32'd0);
        chk("midsweep_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.b_req  = 1'b1;
        bus.b_addr = 4'hf;
        bus.b_data = 8'h11;
        sweep_check("sweep2");
`else
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
`endif
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
